// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the programmable loop counter controller.
// Contents: controller state encoding, default counter width and the
// direction encoding used for the dir input and the latched configuration.
package counter_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between a host (FSM or pushbutton logic) and the
// counter controller.
//   master: drives start/pause/abort and the dir/limit/one_shot config,
//           observes y/busy/wrap/done.
//   slave : the controller side, the mirror image of master.
interface counter_seq_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             pause;
    logic             abort;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             one_shot;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             wrap;
    logic             done;

    modport master (
        output start, pause, abort, dir, limit, one_shot,
        input  y, busy, wrap, done
    );

    modport slave (
        input  start, pause, abort, dir, limit, one_shot,
        output y, busy, wrap, done
    );
endinterface

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Prescaler for the counter controller: counts 0..PRESCALE-1 while en is
// high and flags the last count with tick (combinational from the
// registered count). clr restarts the count at 0.
// Ports: clk, rst (sync, active-high), clr, en, tick.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    // 8 bits cover the full legal prescale range of 1..255.
    localparam int CW = 8;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Programmable up/down counter sequencer.
// Turns the free-running loop counter into one with a programmable
// direction, terminal limit, one-shot/loop mode, pause/abort and a
// prescaled step rate.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of counter_seq_ctrl_if: start/pause/abort commands,
//          dir/limit/one_shot config (sampled on start), and the registered
//          y/busy/wrap/done status.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    counter_seq_ctrl_if.slave        bus
);
    state_t           state;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_dir;
    logic             cfg_one_shot;
    logic             busy_r;
    logic             wrap_r;
    logic             done_r;

    logic             tick;
    logic             tg_clr;
    logic             tg_en;
    logic             terminal;

    // Any accepted start (restart included) or abort rewinds the prescaler;
    // it only advances in RUN with pause low, so PAUSE resumes mid-period.
    assign tg_clr = bus.start | bus.abort;
    assign tg_en  = (state == RUN) && !bus.pause;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tg_clr),
        .en   (tg_en),
        .tick (tick)
    );

    // Terminal value: limit when counting up, zero when counting down.
    assign terminal = (cfg_dir == DIR_DN) ? (y_r == '0) : (y_r == cfg_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            y_r          <= '0;
            cfg_limit    <= '0;
            cfg_dir      <= DIR_UP;
            cfg_one_shot <= 1'b0;
            busy_r       <= 1'b0;
            wrap_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            done_r <= 1'b0;
            if (bus.abort) begin
                state  <= IDLE;
                y_r    <= '0;
                busy_r <= 1'b0;
            end else if (bus.start) begin
                cfg_dir      <= bus.dir;
                cfg_limit    <= bus.limit;
                cfg_one_shot <= bus.one_shot;
                y_r          <= (bus.dir == DIR_DN) ? bus.limit : '0;
                state        <= RUN;
                busy_r       <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.pause) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            if (!terminal) begin
                                y_r <= (cfg_dir == DIR_DN) ? y_r - WIDTH'(1) : y_r + WIDTH'(1);
                            end else if (cfg_one_shot) begin
                                // y already sits on the terminal value; hold it.
                                done_r <= 1'b1;
                                state  <= DONE;
                                busy_r <= 1'b0;
                            end else begin
                                wrap_r <= 1'b1;
                                y_r    <= (cfg_dir == DIR_DN) ? cfg_limit : '0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!bus.pause) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.y    = y_r;
    assign bus.busy = busy_r;
    assign bus.wrap = wrap_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl. Two instances (PRESCALE=1 and
// PRESCALE=3) share the same command stream; both are checked every cycle
// against a behavioural model, the PRESCALE=1 instance additionally against
// a hand-written vector table and the PRESCALE=3 one against a hand-written
// pause/resume sequence.
module tb_counter_seq_ctrl;

    localparam int W = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(W)) bus1 ();
    counter_seq_ctrl_if #(.WIDTH(W)) bus3 ();

    counter_seq_ctrl #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    counter_seq_ctrl #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int st;
        int y;
        int pre;
        bit dir;
        int lim;
        bit os;
        bit wrap;
        bit done;
    } mdl_t;

    mdl_t m1;
    mdl_t m3;

    function automatic mdl_t mnext(mdl_t m, int p, bit r, bit s, bit pz, bit a,
                                   bit d, int l, bit o);
        mdl_t n;
        bit   at_end;
        n      = m;
        n.wrap = 1'b0;
        n.done = 1'b0;
        if (r) begin
            n.st = M_IDLE; n.y = 0; n.pre = 0; n.dir = 0; n.lim = 0; n.os = 0;
            return n;
        end
        if (a) begin
            n.st = M_IDLE; n.y = 0; n.pre = 0;
            return n;
        end
        if (s) begin
            n.dir = d; n.lim = l; n.os = o; n.pre = 0;
            n.y   = d ? l : 0;
            n.st  = M_RUN;
            return n;
        end
        if (m.st == M_RUN) begin
            if (pz) begin
                n.st = M_PAUSE;
            end else if (m.pre < p - 1) begin
                n.pre = m.pre + 1;
            end else begin
                n.pre  = 0;
                at_end = m.dir ? (m.y == 0) : (m.y == m.lim);
                if (!at_end)   n.y = m.dir ? m.y - 1 : m.y + 1;
                else if (m.os) begin n.done = 1'b1; n.st = M_DONE; end
                else           begin n.wrap = 1'b1; n.y = m.dir ? m.lim : 0; end
            end
        end else if (m.st == M_PAUSE && !pz) begin
            n.st = M_RUN;
        end
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag, input mdl_t m, input logic [W-1:0] y,
                             input logic b, input logic wr, input logic dn);
        cmp({tag, ".y"},    32'(y),  32'(m.y));
        cmp({tag, ".busy"}, 32'(b),  32'((m.st == M_RUN) || (m.st == M_PAUSE)));
        cmp({tag, ".wrap"}, 32'(wr), 32'(m.wrap));
        cmp({tag, ".done"}, 32'(dn), 32'(m.done));
    endtask

    // Apply one cycle of inputs to both instances and the model, then
    // compare after the edge.
    task automatic cycle(input bit r, input bit s, input bit pz, input bit a,
                         input bit d, input int l, input bit o);
        logic [W-1:0] lv;
        lv = W'(l);
        rst = r;
        bus1.start = s; bus1.pause = pz; bus1.abort = a;
        bus1.dir = d;   bus1.limit = lv; bus1.one_shot = o;
        bus3.start = s; bus3.pause = pz; bus3.abort = a;
        bus3.dir = d;   bus3.limit = lv; bus3.one_shot = o;
        m1 = mnext(m1, 1, r, s, pz, a, d, l, o);
        m3 = mnext(m3, 3, r, s, pz, a, d, l, o);
        @(posedge clk);
        #1;
        cmp_model("p1", m1, bus1.y, bus1.busy, bus1.wrap, bus1.done);
        cmp_model("p3", m3, bus3.y, bus3.busy, bus3.wrap, bus3.done);
    endtask

    // ---------------- directed vector table (PRESCALE=1) ----------------
    typedef struct {
        bit rst, start, pause, abort, dir;
        int lim;
        bit os;
        int ey;
        bit eb, ew, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit s, bit pz, bit a, bit d, int l, bit o,
                               int ey, bit eb, bit ew, bit ed);
        vec_t x;
        x.rst = r; x.start = s; x.pause = pz; x.abort = a; x.dir = d;
        x.lim = l; x.os = o; x.ey = ey; x.eb = eb; x.ew = ew; x.ed = ed;
        return x;
    endfunction

    // expected y for the PRESCALE=3 pause sequence, one entry per edge
    int seq3_y[18] = '{0,0,0,1,1,1,2,2,2,2,2,2,2,2,3,3,3,4};

    initial begin
        bus1.start = 0; bus1.pause = 0; bus1.abort = 0; bus1.dir = 0; bus1.limit = '0; bus1.one_shot = 0;
        bus3.start = 0; bus3.pause = 0; bus3.abort = 0; bus3.dir = 0; bus3.limit = '0; bus3.one_shot = 0;
        m1 = '{st: M_IDLE, y: 0, pre: 0, dir: 0, lim: 0, os: 0, wrap: 0, done: 0};
        m3 = m1;

        // reset state
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        // up, limit 5, loop: 0..5 then wrap to 0, then 1
        tbl.push_back(v(0,1,0,0,0,5,0, 0,1,0,0));
        for (int k = 1; k <= 5; k++) tbl.push_back(v(0,0,0,0,0,0,0, k,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        // down, limit 3, one-shot: 3,2,1,0 then done
        tbl.push_back(v(0,1,0,0,1,3,1, 3,1,0,0));
        for (int k = 2; k >= 0; k--) tbl.push_back(v(0,0,0,0,0,0,0, k,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,1));
        // config inputs ignored without start
        tbl.push_back(v(0,0,0,0,1,9,1, 0,0,0,0));
        // count up to 7, abort, then start+abort together
        tbl.push_back(v(0,1,0,0,0,15,0, 0,1,0,0));
        for (int k = 1; k <= 7; k++) tbl.push_back(v(0,0,0,0,0,0,0, k,1,0,0));
        tbl.push_back(v(0,0,0,1,0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,0,1,0,9,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0));
        // restart at y=9 with down/limit 4
        tbl.push_back(v(0,1,0,0,0,15,0, 0,1,0,0));
        for (int k = 1; k <= 9; k++) tbl.push_back(v(0,0,0,0,0,0,0, k,1,0,0));
        tbl.push_back(v(0,1,0,0,1,4,0, 4,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 3,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,1,0,0));
        // limit 0 loop: wrap every tick; pause suppresses it
        tbl.push_back(v(0,1,0,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,1,0));
        tbl.push_back(v(0,0,1,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,1,0));
        // reset mid-run beats a simultaneous start
        tbl.push_back(v(0,1,0,0,0,5,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,1,0,0));
        tbl.push_back(v(1,1,0,0,0,5,0, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0));
        // start with pause: start wins, pause from next cycle
        tbl.push_back(v(0,1,1,0,0,5,0, 0,1,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        // down loop reload
        tbl.push_back(v(0,1,0,0,1,2,0, 2,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,1,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        // up one-shot holds limit in DONE; pause ignored there; abort clears
        tbl.push_back(v(0,1,0,0,0,2,1, 0,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 1,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,0,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0, 2,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0, 2,0,0,0));
        tbl.push_back(v(0,0,0,1,0,0,0, 0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i].rst, tbl[i].start, tbl[i].pause, tbl[i].abort,
                  tbl[i].dir, tbl[i].lim, tbl[i].os);
            cmp({tag, ".y"},    32'(bus1.y),    32'(tbl[i].ey));
            cmp({tag, ".busy"}, 32'(bus1.busy), 32'(tbl[i].eb));
            cmp({tag, ".wrap"}, 32'(bus1.wrap), 32'(tbl[i].ew));
            cmp({tag, ".done"}, 32'(bus1.done), 32'(tbl[i].ed));
        end

        // PRESCALE=3 pause/resume: step every 3 edges, pause 4 cycles mid-period
        cycle(1,0,0,0,0,0,0);
        for (int k = 0; k < 18; k++) begin
            string tag;
            tag = $sformatf("pre3_k%0d", k);
            cycle(0, (k == 0), (k >= 8 && k <= 11), 0, 0, 15, 0);
            cmp({tag, ".y"},    32'(bus3.y),    32'(seq3_y[k]));
            cmp({tag, ".busy"}, 32'(bus3.busy), 32'd1);
            cmp({tag, ".wrap"}, 32'(bus3.wrap), 32'd0);
        end

        // randomized command stream against the model
        begin
            bit pz;
            pz = 1'b0;
            cycle(1,0,0,0,0,0,0);
            for (int i = 0; i < 600; i++) begin
                bit s, a, r;
                if ($urandom_range(0, 3) == 0) pz = ~pz;
                s = ($urandom_range(0, 11) == 0);
                a = ($urandom_range(0, 29) == 0);
                r = ($urandom_range(0, 149) == 0);
                cycle(r, s, pz, a, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Controller that sequences the team's free-running 4-bit loop counter into a programmable one.
- Programmable features: up/down direction, terminal limit, one-shot or looping mode, pause/abort and a prescaled step rate.
- Accepts start/pause/abort commands from a host FSM or pushbuttons.
- Drives the count value y with busy/wrap/done status for downstream display or sequencing logic.

Parameters:
WIDTH, 4, counter width in bits (y, limit).
PRESCALE, 1, clock cycles per count step; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset is synchronous and active-high; one clock
start  input  1  single-cycle command: latch config and begin counting
pause  input  1  level; while high in RUN, count and prescaler freeze
abort  input  1  single-cycle command: stop and return to IDLE
dir  input  1  0 = count up, 1 = count down; sampled on accepted start
limit  input  WIDTH  up: terminal value; down: reload/start value; sampled on start
one_shot  input  1  1 = stop at terminal, 0 = loop; sampled on start
y  output  WIDTH  current count, registered
busy  output  1  high in RUN or PAUSE
wrap  output  1  one-cycle pulse on loop-mode wrap/reload
done  output  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset: state=IDLE, y=0, busy=0, wrap=0, done=0, prescaler=0, latched config cleared (dir=0, limit=0, one_shot=0).
- States:
  - IDLE: y=0.
  - RUN: counting.
  - PAUSE: frozen.
  - DONE: y holds final value, busy=0.
- Command priority per cycle: rst > abort > start > pause.
- start, accepted in any state:
  - Latches dir/limit/one_shot.
  - Clears prescaler.
  - Loads y (up: 0, down: limit).
  - Enters RUN; visible on the edge where start is sampled.
  - start during RUN/PAUSE is a restart.
- abort in any non-IDLE state: next edge y=0, IDLE, no done/wrap pulse.
- Prescaler counts 0..PRESCALE-1 only in RUN.
  - tick = (prescaler == PRESCALE-1), then prescaler wraps to 0.
  - First step occurs PRESCALE edges after the start edge; PRESCALE=1 steps every edge.
- RUN and pause=1: next edge enters PAUSE; prescaler and y hold. pause=0 in PAUSE: return to RUN, resume from held prescaler value.
- Step on tick, up:
  - If y != limit, y=y+1.
  - Else loop: y=0, wrap=1.
  - Else one-shot: y holds limit, done=1, DONE.
- Step on tick, down:
  - If y != 0, y=y-1.
  - Else loop: y=limit, wrap=1.
  - Else one-shot: y holds 0, done=1, DONE.
- limit=0 boundary: every tick is terminal. Loop mode gives a wrap pulse each tick with y=0; one-shot completes on the first tick.
- wrap and done are registered, asserted exactly one cycle, never both in one cycle.
- busy=1 exactly in RUN and PAUSE, registered with the state.
- Arithmetic is modulo 2^WIDTH. Since y never exceeds limit upward or drops below 0 downward, no natural overflow occurs.
- pause asserted together with start: start wins; pause takes effect from the following cycle.
- Inputs dir/limit/one_shot are ignored except on an accepted start.

Decomposition:
- Package counter_ctrl_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Default WIDTH=4.
  - Direction constants DIR_UP=0, DIR_DN=1.
- Sub-module tick_gen:
  - Ports: clk, rst, clr, en, tick.
  - Parameter: PRESCALE.
  - Isolates prescaler counting and tick generation from the FSM.

Test Plan:
- Reset then start with dir=0, limit=5, one_shot=0, PRESCALE=1 -> y sequence 0,1,2,3,4,5,0,1; wrap pulses for exactly one cycle coincident with y returning to 0; busy=1 throughout.
- Start with dir=1, limit=3, one_shot=1 -> y sequence 3,2,1,0; done pulses one cycle after y=0 is held; y stays 0, busy=0, state DONE; no wrap seen.
- PRESCALE=3, dir=0, limit=15, loop; hold pause high for 4 cycles while y=2 -> y advances every 3 cycles; y stays 2 and busy stays 1 during pause; after release the next step lands after the remaining prescale cycles.
- Abort at y=7 while counting up, then start and abort asserted in the same cycle -> y=0, IDLE, busy=0 next edge; no done or wrap pulse.
- Start again mid-count at y=9 with new config dir=1, limit=4 -> y=4 on the next edge, then 3,2,...; prescaler restarts from 0.
- limit=0, one_shot=0 -> y stays 0 with a wrap pulse on every tick. Then rst asserted mid-run -> all outputs return to reset values on the next edge.
